// File: rtl/asi_pkg.sv
// Shared AXI definitions for the ASI slave / ASM master pair: bus widths,
// burst/size encodings, master write-engine limits and the burst-split helper.
package asi_pkg;

  localparam int AXI_DW = 128;
  localparam int AXI_AW = 40;
  localparam int AXI_IW = 8;
  localparam int AXI_LW = 8;
  localparam int AXI_SW = AXI_DW / 8;
  localparam int CMD_LW = 16;

  localparam logic [AXI_IW-1:0] MST_ID = '0;
  localparam int MST_BL       = 16;
  localparam int MST_OD       = 4;
  localparam int BOUNDARY_4KB = 4096;

  localparam int LEN_W      = $clog2(MST_BL + 1);
  localparam int OD_W       = $clog2(MST_OD + 1);
  localparam int BEAT_SH    = $clog2(AXI_SW);
  localparam int PAGE_MSB   = $clog2(BOUNDARY_4KB) - 1;
  localparam int PAGE_BEATS = BOUNDARY_4KB / AXI_SW;

  localparam logic [OD_W-1:0] OD_MAX = OD_W'(MST_OD);

  localparam logic [1:0] BT_FIXED = 2'b00;
  localparam logic [1:0] BT_INCR  = 2'b01;
  localparam logic [1:0] BT_WRAP  = 2'b10;

  localparam logic [2:0] TRSIZE_1B   = 3'd0;
  localparam logic [2:0] TRSIZE_2B   = 3'd1;
  localparam logic [2:0] TRSIZE_4B   = 3'd2;
  localparam logic [2:0] TRSIZE_8B   = 3'd3;
  localparam logic [2:0] TRSIZE_16B  = 3'd4;
  localparam logic [2:0] TRSIZE_32B  = 3'd5;
  localparam logic [2:0] TRSIZE_64B  = 3'd6;
  localparam logic [2:0] TRSIZE_128B = 3'd7;
  localparam logic [2:0] AXI_SIZE    = 3'(BEAT_SH);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DRAIN,
    S_FIN
  } asm_state_e;

  // Beats in the next burst: limited by what is left, the burst cap, and the
  // beats remaining before the next 4 KB page so no burst straddles a page.
  function automatic logic [LEN_W-1:0] burst_len(input logic [AXI_AW-1:0] addr,
                                                 input logic [CMD_LW-1:0] rem);
    logic [31:0] page_left;
    logic [31:0] len;
    page_left = 32'(PAGE_BEATS) - 32'(addr[PAGE_MSB:BEAT_SH]);
    len       = 32'(rem);
    if (len > 32'(MST_BL)) len = 32'(MST_BL);
    if (len > page_left)   len = page_left;
    return LEN_W'(len);
  endfunction

endpackage

// File: rtl/asm_w_if.sv
// AXI4 write channels (AW, W, B) between the asm_w master and an interconnect.
interface asm_w_if;
  import asi_pkg::*;

  logic [AXI_IW-1:0] AWID;
  logic [AXI_AW-1:0] AWADDR;
  logic [AXI_LW-1:0] AWLEN;
  logic [2:0]        AWSIZE;
  logic [1:0]        AWBURST;
  logic              AWVALID;
  logic              AWREADY;

  logic [AXI_DW-1:0] WDATA;
  logic [AXI_SW-1:0] WSTRB;
  logic              WLAST;
  logic              WVALID;
  logic              WREADY;

  logic [AXI_IW-1:0] BID;
  logic [1:0]        BRESP;
  logic              BVALID;
  logic              BREADY;

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY
  );

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY
  );
endinterface

// File: rtl/asm_len_fifo.sv
// Small synchronous FIFO carrying the beat count of each accepted AW burst
// to the W channel, so W only runs for bursts whose address has gone out.
module asm_len_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_q];

  // NOTE: storage has no reset; the count and pointers alone define validity.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= bump(wr_q);
      if (do_pop)  rd_q <= bump(rd_q);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/asm_w.sv
// AXI4 master write engine: splits a (address, beats) command into 4 KB-safe
// INCR bursts, streams user data onto W and reports completion from B.
module asm_w
  import asi_pkg::*;
(
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [AXI_AW-1:0] cmd_addr,
  input  logic [CMD_LW-1:0] cmd_beats,
  input  logic              wd_valid,
  output logic              wd_ready,
  input  logic [AXI_DW-1:0] wd_data,
  input  logic [AXI_SW-1:0] wd_strb,
  output logic              done,
  output logic              done_err,
  output logic              busy,
  asm_w_if.master           axi
);

  asm_state_e        state_q, state_d;
  logic [AXI_AW-1:0] addr_q, addr_d;
  logic [CMD_LW-1:0] rem_q, rem_d;
  logic              awvalid_q, awvalid_d;
  logic [OD_W-1:0]   outst_q, outst_d;
  logic              err_q, err_d;
  logic [LEN_W-1:0]  beat_q, beat_d;
  logic              live_q;

  logic [LEN_W-1:0]  cur_len;
  logic [LEN_W-1:0]  fifo_head;
  logic              fifo_full, fifo_empty;
  logic              aw_hs, w_hs, b_hs, wlast;
  logic              unused_bits;

  assign cur_len = burst_len(addr_q, rem_q);
  assign aw_hs   = awvalid_q && axi.AWREADY;
  assign w_hs    = axi.WVALID && axi.WREADY;
  assign b_hs    = axi.BVALID && live_q;
  assign wlast   = !fifo_empty && (beat_q == fifo_head - LEN_W'(1));

  assign unused_bits = ^{axi.BID, axi.BRESP[0], cmd_addr[BEAT_SH-1:0], fifo_full};

  asm_len_fifo #(
    .DEPTH (MST_OD),
    .WIDTH (LEN_W)
  ) u_len_fifo (
    .clk_i   (ACLK),
    .rst_i   (ARESET),
    .push_i  (aw_hs),
    .data_i  (cur_len),
    .pop_i   (w_hs && wlast),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // A B without a matching outstanding burst is ignored rather than wrapping.
  always_comb begin
    outst_d = outst_q;
    if (aw_hs && !(b_hs && outst_q != '0))      outst_d = outst_q + OD_W'(1);
    else if (!aw_hs && b_hs && outst_q != '0)   outst_d = outst_q - OD_W'(1);
  end

  // NOTE: every comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    awvalid_d = 1'b0;
    err_d     = err_q | (b_hs & axi.BRESP[1]);
    beat_d    = beat_q;

    if (w_hs) beat_d = wlast ? '0 : beat_q + LEN_W'(1);

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          addr_d = {cmd_addr[AXI_AW-1:BEAT_SH], {BEAT_SH{1'b0}}};
          rem_d  = cmd_beats;
          err_d  = 1'b0;
          if (cmd_beats == '0) begin
            state_d = S_FIN;
          end else begin
            state_d   = S_ADDR;
            awvalid_d = 1'b1;
          end
        end
      end
      S_ADDR: begin
        if (aw_hs) begin
          addr_d = addr_q + (AXI_AW'(cur_len) << BEAT_SH);
          rem_d  = rem_q - CMD_LW'(cur_len);
        end
        // A pending AW never drops: it was only raised with outst_q < MST_OD.
        if (rem_d == '0) state_d = S_DRAIN;
        else             awvalid_d = (outst_d < OD_MAX);
      end
      S_DRAIN: begin
        if (fifo_empty && outst_d == '0) state_d = S_FIN;
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      awvalid_q <= 1'b0;
      outst_q   <= '0;
      err_q     <= 1'b0;
      beat_q    <= '0;
      live_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      awvalid_q <= awvalid_d;
      outst_q   <= outst_d;
      err_q     <= err_d;
      beat_q    <= beat_d;
      live_q    <= 1'b1;
    end
  end

  assign cmd_ready = live_q && (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FIN);
  assign done_err  = (state_q == S_FIN) && err_q;

  assign axi.AWID    = MST_ID;
  assign axi.AWADDR  = addr_q;
  assign axi.AWLEN   = AXI_LW'(cur_len - LEN_W'(1));
  assign axi.AWSIZE  = AXI_SIZE;
  assign axi.AWBURST = BT_INCR;
  assign axi.AWVALID = awvalid_q;

  assign axi.WDATA  = wd_data;
  assign axi.WSTRB  = wd_strb;
  assign axi.WLAST  = wlast;
  assign axi.WVALID = wd_valid && !fifo_empty;
  assign wd_ready   = axi.WREADY && !fifo_empty;

  assign axi.BREADY = live_q;

endmodule

// File: doc/asm_w.md
# asm_w

AXI4 master write engine: the initiator counterpart to the ASI write slave. It takes a user command (start address, beat count), splits it into INCR bursts that never cross a 4 KB boundary, and drives AW and W from a user data stream. It collects B responses and signals completion. It sits between an internal DMA/data producer and the AXI interconnect; all transfers are full-width (AXI_DW bits per beat).

## Interface
- AXI_DW, 128, data bus width
- AXI_AW, 40, address width
- AXI_IW, 8, ID width
- AXI_LW, 8, AWLEN width
- MST_BL, 16, max beats per burst (1..256)
- MST_OD, 4, max outstanding bursts (AW accepted, B not yet received)
- CMD_LW, 16, width of cmd_beats
- MST_ID, 0, constant AWID value

Ports:
- ACLK  in  1  clock; only clock in the block
- ARESET  in  1  reset, synchronous, active-high
- cmd_valid / cmd_ready  in/out  1  command handshake
- cmd_addr  in  AXI_AW  start byte address; bits [3:0] ignored (treated as 0)
- cmd_beats  in  CMD_LW  number of AXI_DW beats to write
- wd_valid / wd_ready  in/out  1  user data handshake
- wd_data  in  AXI_DW  write data
- wd_strb  in  AXI_DW/8  byte strobes
- done  out  1  one-cycle completion pulse
- done_err  out  1  valid with done; 1 if any BRESP[1] was set during the command
- busy  out  1  command in progress
- AWID  out  AXI_IW  write address ID
- AWADDR  out  AXI_AW  write address
- AWLEN  out  AXI_LW  burst length minus 1
- AWSIZE  out  3  transfer size
- AWBURST  out  2  burst type
- AWVALID / AWREADY  out/in  1  write address handshake
- WDATA  out  AXI_DW  write data
- WSTRB  out  AXI_DW/8  write strobes
- WLAST  out  1  last beat of burst
- WVALID / WREADY  out/in  1  write data handshake
- BID  in  AXI_IW  response ID
- BRESP  in  2  write response
- BVALID / BREADY  in/out  1  write response handshake

## Operation
- Constant outputs:
  - AWID = MST_ID.
  - AWSIZE = TRSIZE_16B for AXI_DW = 128; in general log2(AXI_DW/8).
  - AWBURST = BT_INCR.
- Control FSM states:
  - IDLE: cmd_ready = 1. On a cmd handshake, latch address and remaining beats, then go to ADDR. If cmd_beats == 0, go to FIN instead.
  - ADDR: if outstanding < MST_OD, present AW. On AWREADY, advance address and remaining; go to DRAIN when remaining hits 0.
  - DRAIN: wait until the length FIFO is empty and outstanding == 0.
  - FIN: pulse done for one cycle, then go to IDLE.
- Burst length: len = min(remaining, MST_BL, 256 − addr[11:4]). AWLEN = len − 1. After each AW handshake: addr += len·16 and remaining −= len.
- W path:
  - Each accepted AW pushes len into the length FIFO.
  - WVALID = wd_valid && fifo non-empty.
  - wd_ready = WREADY && fifo non-empty.
  - WDATA/WSTRB pass through from wd_data/wd_strb.
  - A beat counter raises WLAST when the count equals the FIFO head. The FIFO pops on the WLAST handshake.
  - W never runs ahead of its AW.
- B path:
  - BREADY = 1 at all times outside reset.
  - outstanding +1 on AW handshake, −1 on B handshake. Both in the same cycle leaves it unchanged.
  - BID is not checked.
  - err_sticky |= BRESP[1]; it is cleared on command accept.
- busy = (state != IDLE).

## Timing
- Reset values: cmd_ready 0, AWVALID 0, WVALID 0, BREADY 0, done 0, done_err 0, busy 0. cmd_ready rises in the first cycle after ARESET deasserts.
- AWVALID is registered and asserts the cycle after command accept.
- Once AWVALID is high, AWADDR/AWLEN stay stable until AWREADY. Back-to-back AWs have no bubble.
- AWVALID never waits on WREADY or BVALID, only on the outstanding limit.
- W has zero-cycle combinational pass-through. WVALID can assert the cycle after the first AW handshake.
- done asserts exactly one cycle after the last B handshake. For a zero-beat command, it asserts the cycle after accept, with no AXI traffic.
- Reset mid-operation: the next cycle is IDLE with counters and FIFO cleared and all valids 0. No done pulse is produced.
- The outstanding counter is $clog2(MST_OD+1) bits wide and never exceeds MST_OD.

## Structure
- Shared package asi_pkg: use the existing AXI widths, BT_INCR and TRSIZE_* constants. Add MST_BL, MST_OD and BOUNDARY_4KB = 4096 there.
- One sub-module, asm_len_fifo: a synchronous FIFO with depth MST_OD, width $clog2(MST_BL+1), and full/empty flags. It uses the same clock and reset.

## Test plan
- addr 0x0, beats 16, slave always ready -> one AW: AWADDR 0x0, AWLEN 15. 16 W beats with WLAST on the 16th. done one cycle after B, done_err 0.
- addr 0xFE0, beats 4 -> AW 0xFE0 AWLEN 1, then AW 0x1000 AWLEN 1. There is no 4 KB crossing.
- addr 0x0, beats 40 -> AWs at 0x000/0x100/0x200 with AWLEN 15/15/7. Exactly 40 W beats.
- beats 80 with BVALID held low -> exactly 4 AWs are accepted. The 5th AWVALID asserts only after the first B handshake.
- beats 48, BRESP = SLVERR on the 2nd of 3 responses -> done with done_err 1. A following clean command reports done_err 0.
- ARESET pulsed mid-W-burst -> all valids 0 next cycle and no done pulse. A following beats-0 command gives done one cycle after accept with no AWVALID.
